frame_ram_arbiter: RTL and testbench

Shares the single-port compressed-frame RAM between the display-side Huffman chunk decoder and a host writer that loads new compressed frames. Implements double buffering: the decoder always reads the front bank, the host reads and writes the back bank. Banks swap only at a display frame boundary, so a frame is never shown half-written. Sits between the decoder's RAM port, the host bus bridge and the physical RAM.

---
 rtl/frame_ram_arbiter.sv | 95 +++++++++
 tb/tb_frame_ram_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/frame_ram_arbiter.sv
// Double-buffered arbiter for the compressed-frame RAM: the display decoder reads the
// front bank with absolute priority, the host uses the back bank, and banks swap on frame end.
module frame_ram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_rd,
    input  logic [ADDR_W-1:0] disp_address,
    input  logic              disp_frame_end,
    output logic [DATA_W-1:0] disp_readdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              host_swap_req,
    output logic              swap_pending,
    output logic              front_bank,
    output logic [ADDR_W:0]   ram_address,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    input  logic [DATA_W-1:0] ram_readdata
);

    typedef enum logic {
        IDLE,
        PENDING
    } swap_state_t;

    swap_state_t       state_q;
    swap_state_t       next_state;
    logic              disp_rd_d;
    logic              host_rd_d;
    logic [DATA_W-1:0] hold_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            front_bank <= 1'b0;
        end else begin
            state_q <= next_state;
            if (state_q == PENDING && disp_frame_end)
                front_bank <= ~front_bank;
        end
    end

    // A swap request arriving together with a frame end only queues; it waits a full frame.
    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:    if (host_swap_req)  next_state = PENDING;
            PENDING: if (disp_frame_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign swap_pending = (state_q == PENDING);

    // Host is locked out while a swap is queued so the soon-to-be front bank stays intact.
    always_comb begin
        host_gnt      = 1'b0;
        ram_write     = 1'b0;
        ram_writedata = '0;
        ram_address   = {front_bank, disp_address};
        if (!disp_rd && host_req && !swap_pending) begin
            host_gnt      = 1'b1;
            ram_write     = host_we;
            ram_writedata = host_wdata;
            ram_address   = {~front_bank, host_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_rd_d <= 1'b0;
            host_rd_d <= 1'b0;
            hold_q    <= '0;
        end else begin
            disp_rd_d <= disp_rd;
            host_rd_d <= host_gnt & ~host_we;
            if (disp_rd_d)
                hold_q <= ram_readdata;
        end
    end

    // The decoder keeps seeing its last word even when the host has used the RAM since.
    assign disp_readdata = disp_rd_d ? ram_readdata : hold_q;
    assign host_rvalid   = host_rd_d;
    assign host_rdata    = host_rd_d ? ram_readdata : '0;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_frame_ram_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              disp_rd;
    logic [ADDR_W-1:0] disp_address;
    logic              disp_frame_end;
    logic [DATA_W-1:0] disp_readdata;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              host_swap_req;
    logic              swap_pending;
    logic              front_bank;
    logic [ADDR_W:0]   ram_address;
    logic              ram_write;
    logic [DATA_W-1:0] ram_writedata;
    logic [DATA_W-1:0] ram_readdata;

    logic [DATA_W-1:0] mem [0:(1<<(ADDR_W+1))-1];

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    frame_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_rd(disp_rd), .disp_address(disp_address), .disp_frame_end(disp_frame_end),
        .disp_readdata(disp_readdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_swap_req(host_swap_req), .swap_pending(swap_pending), .front_bank(front_bank),
        .ram_address(ram_address), .ram_write(ram_write), .ram_writedata(ram_writedata),
        .ram_readdata(ram_readdata)
    );

    // Registered-read RAM; a read in the write cycle returns the old word.
    always @(posedge clk) begin
        ram_readdata <= mem[ram_address];
        if (ram_write)
            mem[ram_address] <= ram_writedata;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Inputs change 1 ns after the rising edge; checks run 2 ns after it.
    task automatic applyStimulus(input logic rst_v, input logic rd, input logic [ADDR_W-1:0] daddr,
                                 input logic fend, input logic req, input logic we,
                                 input logic [ADDR_W-1:0] haddr, input logic [DATA_W-1:0] wdata,
                                 input logic swap);
        @(posedge clk);
        #1;
        rst_n          = rst_v;
        disp_rd        = rd;
        disp_address   = daddr;
        disp_frame_end = fend;
        host_req       = req;
        host_we        = we;
        host_addr      = haddr;
        host_wdata     = wdata;
        host_swap_req  = swap;
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << (ADDR_W + 1)); i++)
            mem[i] = '0;
        mem[17'h00010] = 32'h1111_0010;
        mem[17'h00040] = 32'h3333_0040;
        mem[17'h10020] = 32'h2222_0020;
        mem[17'h00020] = 32'h4444_0020;
        mem[17'h10010] = 32'h5555_0010;
        mem[17'h00005] = 32'h6666_0005;
        ram_readdata = '0;

        rst_n = 1'b0; disp_rd = 1'b0; disp_address = '0; disp_frame_end = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_swap_req = 1'b0;

        applyStimulus(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 32'h0, 0);
        applyStimulus(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 32'h0, 0);
        checkOutput("rst_front_bank",   front_bank,    0);
        checkOutput("rst_swap_pending", swap_pending,  0);
        checkOutput("rst_host_gnt",     host_gnt,      0);
        checkOutput("rst_host_rvalid",  host_rvalid,   0);
        checkOutput("rst_host_rdata",   host_rdata,    0);
        checkOutput("rst_disp_rdata",   disp_readdata, 0);
        checkOutput("rst_ram_write",    ram_write,     0);

        applyStimulus(1, 1, 16'h0010, 0, 0, 0, 16'h0000, 32'h0, 0);
        checkOutput("disp_addr",     ram_address, 17'h00010);
        checkOutput("disp_no_gnt",   host_gnt,    0);
        checkOutput("disp_no_write", ram_write,   0);

        applyStimulus(1, 0, 16'h0000, 0, 1, 1, 16'h0005, 32'hDEADBEEF, 0);
        checkOutput("disp_rdata_n1", disp_readdata, 32'h1111_0010);
        checkOutput("wr_gnt",        host_gnt,      1);
        checkOutput("wr_strobe",     ram_write,     1);
        checkOutput("wr_addr",       ram_address,   17'h10005);
        checkOutput("wr_data",       ram_writedata, 32'hDEADBEEF);

        applyStimulus(1, 1, 16'h0040, 0, 1, 0, 16'h0020, 32'h0, 0);
        checkOutput("alt_disp_gnt",  host_gnt,      0);
        checkOutput("alt_disp_addr", ram_address,   17'h00040);
        checkOutput("hold_after_wr", disp_readdata, 32'h1111_0010);
        checkOutput("no_rvalid_wr",  host_rvalid,   0);

        applyStimulus(1, 0, 16'h0000, 0, 1, 0, 16'h0020, 32'h0, 0);
        checkOutput("alt_host_gnt",  host_gnt,      1);
        checkOutput("alt_host_addr", ram_address,   17'h10020);
        checkOutput("alt_host_nowr", ram_write,     0);
        checkOutput("disp_rdata_40", disp_readdata, 32'h3333_0040);

        applyStimulus(1, 1, 16'h0010, 0, 1, 0, 16'h0020, 32'h0, 0);
        checkOutput("rd_rvalid",     host_rvalid,   1);
        checkOutput("rd_rdata",      host_rdata,    32'h2222_0020);
        checkOutput("alt_gnt_again", host_gnt,      0);
        checkOutput("hold_in_host",  disp_readdata, 32'h3333_0040);

        applyStimulus(1, 0, 16'h0000, 0, 1, 0, 16'h0005, 32'h0, 1);
        checkOutput("gnt_with_swap", host_gnt,      1);
        checkOutput("disp_rdata_10", disp_readdata, 32'h1111_0010);

        applyStimulus(1, 0, 16'h0000, 0, 1, 0, 16'h0020, 32'h0, 0);
        checkOutput("wr_readback",   host_rdata,    32'hDEADBEEF);
        checkOutput("pend_set",      swap_pending,  1);
        checkOutput("pend_no_gnt",   host_gnt,      0);
        checkOutput("pend_front",    front_bank,    0);

        applyStimulus(1, 0, 16'h0000, 1, 1, 0, 16'h0020, 32'h0, 0);
        checkOutput("fend_no_gnt",   host_gnt,      0);
        checkOutput("fend_pending",  swap_pending,  1);

        applyStimulus(1, 0, 16'h0000, 0, 1, 0, 16'h0020, 32'h0, 0);
        checkOutput("swap_front",    front_bank,    1);
        checkOutput("swap_cleared",  swap_pending,  0);
        checkOutput("post_swap_gnt", host_gnt,      1);
        checkOutput("post_swap_adr", ram_address,   17'h00020);

        applyStimulus(1, 1, 16'h0010, 0, 0, 0, 16'h0000, 32'h0, 0);
        checkOutput("bank0_rdata",   host_rdata,    32'h4444_0020);
        checkOutput("front1_addr",   ram_address,   17'h10010);

        applyStimulus(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 32'h0, 1);
        checkOutput("front1_rdata",  disp_readdata, 32'h5555_0010);

        applyStimulus(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 32'h0, 0);
        checkOutput("coinc_front",   front_bank,    1);
        checkOutput("coinc_pending", swap_pending,  1);

        applyStimulus(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 32'h0, 0);
        checkOutput("coinc_wait",    front_bank,    1);

        applyStimulus(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 32'h0, 0);
        checkOutput("coinc_toggle",  front_bank,    0);
        checkOutput("coinc_clear",   swap_pending,  0);

        applyStimulus(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 32'h0, 1);
        applyStimulus(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 32'h0, 0);
        checkOutput("swap2_pending", swap_pending,  1);

        applyStimulus(1, 0, 16'h0000, 0, 1, 0, 16'h0005, 32'h0, 1);
        checkOutput("swap2_front",   front_bank,    1);
        checkOutput("swap2_gnt",     host_gnt,      1);
        checkOutput("swap2_addr",    ram_address,   17'h00005);

        applyStimulus(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 32'h0, 0);
        checkOutput("pre_rst_rvld",  host_rvalid,   1);
        checkOutput("pre_rst_rdata", host_rdata,    32'h6666_0005);
        checkOutput("pre_rst_pend",  swap_pending,  1);

        applyStimulus(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 32'h0, 0);
        checkOutput("mid_rst_rvld",  host_rvalid,   0);
        checkOutput("mid_rst_pend",  swap_pending,  0);
        checkOutput("mid_rst_front", front_bank,    0);
        checkOutput("mid_rst_disp",  disp_readdata, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
